sonic_ranger: RTL

Ultrasonic HC-SR04 front-end for the line-following car. It sits upstream of the motor stage and the 7-segment display path.
- Periodically fires trig and times the echo pulse in millimetre ticks.
- Converts the result to BCD for the display.
- Produces a hysteretic, filtered obstacle stop flag that gates the motors.

---
 rtl/sonic_ranger_pkg.sv | 30 +++
 rtl/sonic_ranger_bin2bcd.sv | 61 ++++++
 rtl/sonic_ranger.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sonic_ranger_pkg.sv
// Shared types and constants for the HC-SR04 ranging front-end.
`timescale 1ns/1ps
package sonic_ranger_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_CONV,
        S_UPDATE
    } state_t;

    localparam int DIST_W = 12;
    localparam int BCD_W  = 16;
    localparam logic [DIST_W-1:0] DIST_SAT = 12'hFFF;

    // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int d = 0; d < BCD_W / 4; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) begin
                res[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sonic_ranger_bin2bcd.sv
// Iterative double-dabble converter: one bit per cycle, done pulses 12 cycles after start.
`timescale 1ns/1ps
module sonic_ranger_bin2bcd
    import sonic_ranger_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIST_W-1:0] bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              done
);

    localparam logic [3:0] LAST_BIT = 4'(DIST_W - 1);

    logic              r_busy;
    logic [3:0]        r_cnt;
    logic [DIST_W-1:0] r_sh;
    logic [BCD_W-1:0]  r_acc;
    logic [BCD_W-1:0]  r_bcd;
    logic              r_done;

    logic [BCD_W-1:0]  w_adj;
    logic [BCD_W-1:0]  w_acc_next;

    assign w_adj      = dabble_adjust(r_acc);
    assign w_acc_next = {w_adj[BCD_W-2:0], r_sh[DIST_W-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_sh   <= '0;
            r_acc  <= '0;
            r_bcd  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_acc <= w_acc_next;
                r_sh  <= {r_sh[DIST_W-2:0], 1'b0};
                if (r_cnt == LAST_BIT) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_bcd  <= w_acc_next;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end else if (start) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_sh   <= bin;
                r_acc  <= '0;
            end
        end
    end

    assign bcd  = r_bcd;
    assign done = r_done;

endmodule

// File: rtl/sonic_ranger.sv
// HC-SR04 front-end: periodic trigger, echo timing in mm, BCD conversion and hysteretic stop flag.
`timescale 1ns/1ps
module sonic_ranger
    import sonic_ranger_pkg::*;
#(
    parameter int TRIG_CYC    = 1000,
    parameter int PERIOD_CYC  = 6000000,
    parameter int TIMEOUT_CYC = 3000000,
    parameter int MM_DIV      = 583,
    parameter int STOP_MM     = 150,
    parameter int RELEASE_MM  = 200,
    parameter int STOP_CNT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        echo,
    output logic        trig,
    output logic [11:0] dist_mm,
    output logic [15:0] dist_bcd,
    output logic        oor,
    output logic        valid,
    output logic        stop
);

    localparam int CNT_MAX = (TIMEOUT_CYC > TRIG_CYC) ? TIMEOUT_CYC : TRIG_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PER_W   = $clog2(PERIOD_CYC + 1);
    localparam int PRE_W   = $clog2(MM_DIV + 1);
    localparam int NEAR_W  = $clog2(STOP_CNT + 1);

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYC - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(MM_DIV - 1);
    localparam logic [NEAR_W-1:0] NEAR_MAX  = NEAR_W'(STOP_CNT);
    localparam logic [DIST_W-1:0] STOP_LIM  = DIST_W'(STOP_MM);
    localparam logic [DIST_W-1:0] REL_LIM   = DIST_W'(RELEASE_MM);

    state_t             r_state;
    logic               r_first;
    logic               r_echo_s1, r_echo_s2, r_echo_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [PER_W-1:0]   r_period_cnt;
    logic [PRE_W-1:0]   r_pre;
    logic [DIST_W-1:0]  r_mm;
    logic [DIST_W-1:0]  r_cap;
    logic               r_oor_cap;
    logic               r_start;
    logic [NEAR_W-1:0]  r_near;
    logic               r_trig;
    logic [DIST_W-1:0]  r_dist;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_oor;
    logic               r_valid;
    logic               r_stop;

    logic               w_rise, w_fall, w_tick, w_sat;
    logic [DIST_W-1:0]  w_mm_inc;
    logic               w_near, w_far;
    logic [NEAR_W-1:0]  w_near_inc;
    logic [BCD_W-1:0]   w_bcd;
    logic               w_done;

    assign w_rise     = r_echo_s2 & ~r_echo_d;
    assign w_fall     = ~r_echo_s2 & r_echo_d;
    // The current cycle is counted too, so a fall cycle can still complete a millimetre.
    assign w_tick     = (r_pre == PRE_LAST);
    assign w_mm_inc   = r_mm + (w_tick ? DIST_W'(1) : DIST_W'(0));
    assign w_sat      = (w_mm_inc == DIST_SAT);
    assign w_near     = !r_oor_cap && (r_cap < STOP_LIM);
    assign w_far      = r_oor_cap || (r_cap >= REL_LIM);
    assign w_near_inc = (r_near == NEAR_MAX) ? r_near : r_near + NEAR_W'(1);

    sonic_ranger_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (r_start),
        .bin   (r_cap),
        .bcd   (w_bcd),
        .done  (w_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_first      <= 1'b1;
            r_echo_s1    <= 1'b0;
            r_echo_s2    <= 1'b0;
            r_echo_d     <= 1'b0;
            r_cnt        <= '0;
            r_period_cnt <= '0;
            r_pre        <= '0;
            r_mm         <= '0;
            r_cap        <= '0;
            r_oor_cap    <= 1'b0;
            r_start      <= 1'b0;
            r_near       <= '0;
            r_trig       <= 1'b0;
            r_dist       <= '0;
            r_bcd        <= '0;
            r_oor        <= 1'b0;
            r_valid      <= 1'b0;
            r_stop       <= 1'b1;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
            r_valid   <= 1'b0;
            r_start   <= 1'b0;
            if (r_period_cnt != PER_LAST) begin
                r_period_cnt <= r_period_cnt + PER_W'(1);
            end

            unique case (r_state)
                S_IDLE: begin
                    if (r_first || r_period_cnt == PER_LAST) begin
                        r_first      <= 1'b0;
                        r_trig       <= 1'b1;
                        r_cnt        <= '0;
                        r_period_cnt <= '0;
                        r_state      <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (r_cnt == TRIG_LAST) begin
                        r_trig  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_RISE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_RISE: begin
                    if (w_rise) begin
                        r_cnt   <= '0;
                        r_pre   <= '0;
                        r_mm    <= '0;
                        r_state <= S_MEASURE;
                    end else if (r_cnt == TO_LAST) begin
                        r_cap     <= DIST_SAT;
                        r_oor_cap <= 1'b1;
                        r_start   <= 1'b1;
                        r_state   <= S_CONV;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
                    r_mm  <= w_mm_inc;
                    // Saturation wins over a coincident fall.
                    if (w_sat || r_cnt == TO_LAST) begin
                        r_cap     <= DIST_SAT;
                        r_oor_cap <= 1'b1;
                        r_start   <= 1'b1;
                        r_state   <= S_CONV;
                    end else if (w_fall) begin
                        r_cap     <= w_mm_inc;
                        r_oor_cap <= 1'b0;
                        r_start   <= 1'b1;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (w_done) begin
                        r_dist  <= r_cap;
                        r_bcd   <= w_bcd;
                        r_oor   <= r_oor_cap;
                        r_valid <= 1'b1;
                        if (w_near) begin
                            r_near <= w_near_inc;
                            if (w_near_inc == NEAR_MAX) begin
                                r_stop <= 1'b1;
                            end
                        end else begin
                            r_near <= '0;
                            if (w_far) begin
                                r_stop <= 1'b0;
                            end
                        end
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign trig     = r_trig;
    assign dist_mm  = r_dist;
    assign dist_bcd = r_bcd;
    assign oor      = r_oor;
    assign valid    = r_valid;
    assign stop     = r_stop;

endmodule
